// File: rtl/always_sync_checker.sv
// Lock/fault monitor for a received line that should hold a constant value.
// Define ALWAYS_SYNC_STICKY_FAULT_EN to make FAULT absorbing until rst.
module always_sync_checker #(
    parameter int LOCK_N = 4,
    parameter int MISS_N = 3,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             expected,  // constant value the source should hold
    output logic             q,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_FAULT   = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_N);
    localparam logic [3:0] MISS_C = 4'(MISS_N);

    state_t     state;
    logic [3:0] run_cnt;
    logic [3:0] miss_cnt;
    logic       match;

    assign match = (din == expected);

    // NOTE: all state is registered with non-blocking assignments so every
    // branch below reads the pre-edge values of the counters and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            q        <= 1'b0;
            locked   <= 1'b0;
            fault    <= 1'b0;
            err_cnt  <= '0;
            run_cnt  <= '0;
            miss_cnt <= '0;
        end else if (en) begin
            q <= din;
            case (state)
                S_IDLE: begin
                    state   <= S_ACQUIRE;
                    run_cnt <= match ? 4'd1 : 4'd0;
                end

                S_ACQUIRE: begin
                    if (!match) begin
                        run_cnt <= '0;
                    end else if (run_cnt + 4'd1 == LOCK_C) begin
                        state    <= S_LOCKED;
                        locked   <= 1'b1;
                        run_cnt  <= '0;
                        miss_cnt <= '0;
                    end else begin
                        run_cnt <= run_cnt + 4'd1;
                    end
                end

                S_LOCKED: begin
                    if (match) begin
                        miss_cnt <= '0;
                    end else begin
                        // Saturate rather than wrap so a long fault history stays visible.
                        if (err_cnt != {ERR_W{1'b1}}) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                        if (miss_cnt + 4'd1 == MISS_C) begin
                            state    <= S_FAULT;
                            locked   <= 1'b0;
                            fault    <= 1'b1;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 4'd1;
                        end
                    end
                end

                S_FAULT: begin
`ifdef ALWAYS_SYNC_STICKY_FAULT_EN
                    state <= S_FAULT;
`else
                    // Recovery restarts acquisition with this match already counted.
                    if (match) begin
                        state    <= S_ACQUIRE;
                        fault    <= 1'b0;
                        run_cnt  <= 4'd1;
                        miss_cnt <= '0;
                    end
`endif
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_always_sync_checker.sv
// Self-checking bench for always_sync_checker: table of vectors fed through a
// scoreboard queue, plus hand-written reset sequences.
module tb_always_sync_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       expected = 1'b0;
    logic       q, locked, fault;
    logic [7:0] err_cnt;
    logic       q2, locked2, fault2;
    logic [1:0] err2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       q;
        logic       locked;
        logic       fault;
        logic [7:0] err;
        logic [1:0] err2;
    } exp_t;

    typedef struct {
        logic rst_first;
        logic en;
        logic din;
        logic expected;
        exp_t ex;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    always_sync_checker #(.LOCK_N(4), .MISS_N(3), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .expected(expected),
        .q(q), .locked(locked), .fault(fault), .err_cnt(err_cnt)
    );

    always_sync_checker #(.LOCK_N(4), .MISS_N(3), .ERR_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .en(en), .din(din), .expected(expected),
        .q(q2), .locked(locked2), .fault(fault2), .err_cnt(err2)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic qv, input logic lv, input logic fv, input logic [7:0] ev);
        exp_t r;
        r.q      = qv;
        r.locked = lv;
        r.fault  = fv;
        r.err    = ev;
        r.err2   = (ev > 8'd3) ? 2'd3 : ev[1:0];
        return r;
    endfunction

    function automatic void add(input logic rf, input logic e, input logic d, input logic x,
                                input logic qv, input logic lv, input logic fv, input logic [7:0] ev);
        vec_t v;
        v.rst_first = rf;
        v.en        = e;
        v.din       = d;
        v.expected  = x;
        v.ex        = mk(qv, lv, fv, ev);
        vecs.push_back(v);
    endfunction

    // Async reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic apply_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(name, {q, locked, fault, err_cnt, err2, q2, locked2, fault2}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic step(input string name, input logic e, input logic d, input logic x, input exp_t ex);
        exp_t p;
        @(negedge clk);
        en       = e;
        din      = d;
        expected = x;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        check({name, "_main"}, {3'b000, q, locked, fault, err_cnt, err2},
              {3'b000, p.q, p.locked, p.fault, p.err, p.err2});
        check({name, "_narrow"}, {13'd0, q2, locked2, fault2}, {13'd0, p.q, p.locked, p.fault});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Lock on expect=0, single pulse, three misses to FAULT, then recovery.
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 1, 1, 0, 2);
        add(0, 1, 1, 0, 1, 1, 0, 3);
        add(0, 1, 1, 0, 1, 0, 1, 4);
        add(0, 1, 1, 0, 1, 0, 1, 4);
`ifdef ALWAYS_SYNC_STICKY_FAULT_EN
        add(0, 1, 0, 0, 0, 0, 1, 4);
        add(0, 1, 0, 0, 0, 0, 1, 4);
        add(0, 1, 0, 0, 0, 0, 1, 4);
        add(0, 1, 0, 0, 0, 0, 1, 4);
        add(0, 0, 1, 0, 0, 0, 1, 4);
`else
        add(0, 1, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 1, 0, 4);
        add(0, 0, 1, 0, 0, 1, 0, 4);
`endif
        // Run restarted by a mismatch: 0,0,0,1,0,0,0,0 locks only on edge 8.
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        // expect=1 with a mismatching first edge, then expect flips while locked.
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1);
        add(0, 1, 1, 0, 1, 1, 0, 2);
        add(0, 1, 1, 0, 1, 0, 1, 3);
        // Isolated mismatches: narrow counter saturates at 3, wide keeps counting.
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add(0, 1, 1, 0, 1, 1, 0, 8'(k));
            add(0, 1, 0, 0, 0, 1, 0, 8'(k));
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) apply_reset($sformatf("reset_before_vec%0d", i));
            step($sformatf("vec%0d", i), vecs[i].en, vecs[i].din, vecs[i].expected, vecs[i].ex);
        end

        // Reset mid-acquisition discards the partial run.
        apply_reset("reset_e0");
        step("acq_a", 1, 0, 0, mk(0, 0, 0, 0));
        step("acq_b", 1, 0, 0, mk(0, 0, 0, 0));
        apply_reset("reset_mid_acq");
        step("acq_c", 1, 0, 0, mk(0, 0, 0, 0));
        step("acq_d", 1, 0, 0, mk(0, 0, 0, 0));
        step("acq_e", 1, 0, 0, mk(0, 0, 0, 0));
        step("acq_f", 1, 0, 0, mk(0, 1, 0, 0));

        // Reset mid-fault discards the error history.
        step("flt_a", 1, 1, 0, mk(1, 1, 0, 1));
        step("flt_b", 1, 1, 0, mk(1, 1, 0, 2));
        step("flt_c", 1, 1, 0, mk(1, 0, 1, 3));
        apply_reset("reset_mid_fault");
        step("flt_d", 1, 1, 0, mk(1, 0, 0, 0));
        step("flt_e", 1, 0, 0, mk(0, 0, 0, 0));

        check("scoreboard_empty", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/always_sync_checker.md
ALWAYS_SYNC_CHECKER -- requirements
Module: always_sync_checker

Interface
REQ-001 Parameter LOCK_N, default 4: consecutive matching samples needed to declare lock (2..15).
REQ-002 Parameter MISS_N, default 3: consecutive mismatching samples in LOCKED that force FAULT (1..15).
REQ-003 Parameter ERR_W, default 8: width of the error counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  sample enable; when low, no state, counter or q change.
REQ-007 din  input  1  received clocked data; high for one cycle = pulse arrived in that period.
REQ-008 expect  input  1  expected constant line value (0 for an always-0 source, 1 for an always-1 source).
REQ-009 q  output  1  registered copy of din, one-cycle latency.
REQ-010 locked  output  1  high only in state LOCKED.
REQ-011 fault  output  1  high only in state FAULT.
REQ-012 err_cnt  output  ERR_W  saturating count of mismatches seen in LOCKED.

Function
REQ-013 Sample = din on a rising clk edge with en high; match = (din == expect).
REQ-014 q shall equal din from the previous enabled edge; q holds when en is low.
REQ-015 States: IDLE, ACQUIRE, LOCKED, FAULT; 2-bit encoding, no other reachable state.
REQ-016 IDLE -> ACQUIRE on the first enabled edge, regardless of match; run counter loaded with 1 if match, else 0.
REQ-017 ACQUIRE: match increments run counter; mismatch clears it to 0; stay in ACQUIRE.
REQ-018 ACQUIRE -> LOCKED on the edge where the incremented run counter reaches LOCK_N; locked rises that same edge.
REQ-019 LOCKED: match clears miss counter; mismatch increments err_cnt (saturating at all-ones) and miss counter.
REQ-020 LOCKED -> FAULT on the edge where the miss counter reaches MISS_N; that mismatch is still counted in err_cnt.
REQ-021 FAULT behaviour is set by the configuration macro (REQ-027/028); err_cnt does not increment in FAULT, ACQUIRE or IDLE.
REQ-022 A change of expect while LOCKED is treated as ordinary mismatches; no automatic re-acquire.
REQ-023 err_cnt at all-ones shall stay all-ones on further mismatches (no wrap).
REQ-024 locked and fault are never high simultaneously.

Reset
REQ-025 rst high shall immediately (without clk) force state IDLE, q=0, locked=0, fault=0, err_cnt=0, run and miss counters=0.
REQ-026 Reset asserted mid-acquisition or mid-fault discards all progress; first enabled edge after rst falls follows REQ-016.

Configuration
REQ-027 With macro ALWAYS_SYNC_STICKY_FAULT_EN defined: FAULT is absorbing; only rst leaves it.
REQ-028 Without ALWAYS_SYNC_STICKY_FAULT_EN: FAULT -> ACQUIRE on the first enabled edge with a match, run counter set to 1, miss counter cleared, err_cnt retained.

Verification
REQ-029 expect=0, din=0 for 4 enabled edges after reset -> locked=1 on edge 4, err_cnt=0, q=0 throughout.
REQ-030 Locked on expect=0, single din=1 pulse -> q=1 one cycle later, err_cnt=1, remains LOCKED.
REQ-031 Locked, din=1 for 3 consecutive edges (MISS_N=3) -> fault=1 on third edge, locked=0, err_cnt=3.
REQ-032 ACQUIRE with pattern 0,0,0,1,0,0,0,0 (expect=0) -> lock only on the 8th edge (run restarted by mismatch).
REQ-033 ERR_W=2, locked, isolated mismatches separated by matches x5 -> err_cnt sticks at 3.
REQ-034 In FAULT, din=expect: without macro -> ACQUIRE then LOCKED after LOCK_N matches; with macro -> fault stays 1 until rst pulse (async, mid-cycle) clears all outputs.
